// File: rtl/digit_entry_buffer.sv
// -----------------------------------------------------------------------------
// digit_entry_buffer
//
// Multi-digit keypad entry buffer. Collects up to NDIGITS decimal keypresses as
// packed BCD with backspace and clear. ENTER starts a BCD-to-binary conversion
// that processes one digit per cycle. The result is then presented on `value`
// together with a one-cycle `value_valid` pulse.
//
// Optional feature: define SIGN_EN to add a sign flag. KEY_SIGN toggles the
// flag, and it is presented on `value_neg` alongside the result. `value`
// always carries the unsigned magnitude.
//
// Ports:
//   clk          in   system clock, rising edge
//   nrst         in   asynchronous active-low reset
//   keystrobe    in   one-cycle pulse, keycode valid this cycle
//   keycode      in   key identifier, 0-9 are digits
//   isdig        out  keystrobe with a digit keycode (any state)
//   reject       out  keystrobe present but the key is not accepted
//   digits       out  BCD buffer, nibble 0 = least significant digit
//   count        out  number of digits held
//   busy         out  conversion in progress (CONV or DONE)
//   value        out  binary result, held until the next conversion completes
//   value_neg    out  sign of the result (SIGN_EN builds only)
//   value_valid  out  one-cycle pulse when value updates
// -----------------------------------------------------------------------------
module digit_entry_buffer #(
   parameter int         NDIGITS   = 4,
   parameter int         VAL_W     = 14,
   parameter logic [3:0] KEY_BKSP  = 4'hB,
   parameter logic [3:0] KEY_CLR   = 4'hC,
   parameter logic [3:0] KEY_ENTER = 4'hE,
   parameter logic [3:0] KEY_SIGN  = 4'hD
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           keystrobe,
   input  logic [3:0]                     keycode,
   output logic                           isdig,
   output logic                           reject,
   output logic [4*NDIGITS-1:0]           digits,
   output logic [$clog2(NDIGITS+1)-1:0]   count,
   output logic                           busy,
   output logic [VAL_W-1:0]               value,
`ifdef SIGN_EN
   output logic                           value_neg,
`endif
   output logic                           value_valid
);

   localparam int DW = 4 * NDIGITS;
   localparam int CW = $clog2(NDIGITS + 1);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Elaboration-time sanity checks on the parameter set.
   if (NDIGITS < 1) begin : g_bad_ndigits
      $error("digit_entry_buffer: NDIGITS must be >= 1");
   end
   if ((64'd1 << VAL_W) < pow10(NDIGITS)) begin : g_bad_val_w
      $error("digit_entry_buffer: VAL_W too narrow for NDIGITS decimal digits");
   end
   if (KEY_BKSP <= 4'd9 || KEY_CLR <= 4'd9 || KEY_ENTER <= 4'd9 || KEY_SIGN <= 4'd9) begin : g_bad_keys
      $error("digit_entry_buffer: control keycodes must not overlap digits");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [DW-1:0]      digits_q;
   logic [CW-1:0]      count_q;
   logic [IW-1:0]      idx_q;
   logic [VAL_W-1:0]   acc_q;
   logic [VAL_W-1:0]   acc_d;
   logic [VAL_W-1:0]   value_q;
   logic               value_valid_q;
   logic [3:0]         cur_digit;
   logic               full;
   logic               empty;
`ifdef SIGN_EN
   logic               neg_q;
   logic               value_neg_q;
`endif

   assign full  = (count_q == CW'(NDIGITS));
   assign empty = (count_q == '0);

   assign isdig       = keystrobe && (keycode <= 4'd9);
   assign digits      = digits_q;
   assign count       = count_q;
   assign busy        = (state_q != S_IDLE);
   assign value       = value_q;
   assign value_valid = value_valid_q;
`ifdef SIGN_EN
   assign value_neg   = value_neg_q;
`endif

   // Most significant held digit is processed first, so idx walks downward.
   assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

   // acc*10 as shift-and-add.
   always_comb begin
      acc_d = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);
   end

   always_comb begin
      reject = 1'b0;
      if (keystrobe) begin
         if (state_q != S_IDLE) begin
            reject = 1'b1;
         end else if (keycode <= 4'd9) begin
            reject = full;
         end else if (keycode == KEY_BKSP || keycode == KEY_ENTER) begin
            reject = empty;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= S_IDLE;
         digits_q      <= '0;
         count_q       <= '0;
         idx_q         <= '0;
         acc_q         <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
`ifdef SIGN_EN
         neg_q         <= 1'b0;
         value_neg_q   <= 1'b0;
`endif
      end else begin
         value_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (keystrobe) begin
                  if (keycode <= 4'd9) begin
                     if (!full) begin
                        digits_q <= (digits_q << 4) | DW'(keycode);
                        count_q  <= count_q + 1'b1;
                     end
                  end else if (keycode == KEY_BKSP) begin
                     if (!empty) begin
                        digits_q <= digits_q >> 4;
                        count_q  <= count_q - 1'b1;
                     end
                  end else if (keycode == KEY_CLR) begin
                     digits_q <= '0;
                     count_q  <= '0;
`ifdef SIGN_EN
                     neg_q    <= 1'b0;
`endif
                  end else if (keycode == KEY_ENTER) begin
                     if (!empty) begin
                        state_q <= S_CONV;
                        idx_q   <= IW'(count_q - 1'b1);
                        acc_q   <= '0;
                     end
`ifdef SIGN_EN
                  end else if (keycode == KEY_SIGN) begin
                     neg_q <= ~neg_q;
`endif
                  end
               end
            end
            S_CONV: begin
               acc_q <= acc_d;
               if (idx_q == '0) begin
                  // Capture the final sum on DONE entry so value is already
                  // stable while value_valid is high.
                  state_q       <= S_DONE;
                  value_q       <= acc_d;
                  value_valid_q <= 1'b1;
`ifdef SIGN_EN
                  value_neg_q   <= neg_q;
`endif
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            S_DONE: begin
               digits_q <= '0;
               count_q  <= '0;
`ifdef SIGN_EN
               neg_q    <= 1'b0;
`endif
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
